// File: rtl/uart_arb_pkg.sv
// Shared constants and helpers for the UART transmit arbiter.
// Holds the state encoding, the default burst limit and the one-hot to index conversion.
package uart_arb_pkg;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ISSUE     = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;

  localparam int DEFAULT_MAX_BURST = 16;

  // Sized for the largest supported requester count (8).
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] onehot);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (onehot[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
// Returns the first requester at or above ptr, wrapping to the lowest one.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int LOG2_NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]      req,
  input  logic [LOG2_NUM_REQ-1:0] ptr,
  output logic                    valid,
  output logic [LOG2_NUM_REQ-1:0] idx
);

  logic [NUM_REQ-1:0] upper;
  logic [NUM_REQ-1:0] pool;
  logic [NUM_REQ-1:0] onehot;

  // Requests at or above the pointer take priority; fall back to the full set on wrap.
  assign upper  = req & ({NUM_REQ{1'b1}} << ptr);
  assign pool   = (|upper) ? upper : req;
  assign onehot = pool & (~pool + NUM_REQ'(1));
  assign valid  = |req;
  assign idx    = LOG2_NUM_REQ'(onehot_to_idx(8'(onehot)));

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among several byte streams.
// Grants are held for a packet, up to MAX_BURST bytes, and a watchdog guards each byte.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int LOG2_NUM_REQ  = 2,
  parameter int MAX_BURST     = DEFAULT_MAX_BURST,
  parameter int TIMEOUT_WIDTH = 20
) (
  input  logic                    ifclk,
  input  logic                    resetb,
  input  logic                    enable,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ-1:0]      req_last,
  input  logic [8*NUM_REQ-1:0]    req_data,
  output logic [NUM_REQ-1:0]      ack,
  output logic [NUM_REQ-1:0]      grant,
  output logic [7:0]              tx_data,
  output logic                    we,
  input  logic                    tx_busy,
  input  logic                    tx_done,
  output logic [LOG2_NUM_REQ-1:0] active_id,
  output logic                    busy,
  output logic                    timeout_err,
  input  logic                    clear_err
);

  logic [1:0]               state;
  logic [LOG2_NUM_REQ-1:0]  ptr;
  logic [LOG2_NUM_REQ-1:0]  next_ptr;
  logic [7:0]               burst_cnt;
  logic [TIMEOUT_WIDTH-1:0] wdog;
  logic                     last_q;
  logic                     pick_valid;
  logic [LOG2_NUM_REQ-1:0]  pick_idx;
  logic                     issue;
  logic                     wdog_max;
  logic [7:0]               data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_data
    assign data_arr[g] = req_data[8*g +: 8];
  end

  rr_pick #(
    .NUM_REQ      (NUM_REQ),
    .LOG2_NUM_REQ (LOG2_NUM_REQ)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Pointer wraps at NUM_REQ so indices beyond the last requester are never searched first.
  assign next_ptr = (active_id == LOG2_NUM_REQ'(NUM_REQ - 1)) ? '0
                                                              : active_id + LOG2_NUM_REQ'(1);
  assign wdog_max = &wdog;
  assign issue    = (state == ISSUE) && !tx_busy;
  assign we       = issue;
  assign ack      = issue ? (NUM_REQ'(1) << active_id) : '0;
  assign busy     = (state != IDLE);

  always_ff @(posedge ifclk) begin
    if (!resetb) begin
      state       <= IDLE;
      grant       <= '0;
      active_id   <= '0;
      tx_data     <= '0;
      timeout_err <= 1'b0;
      ptr         <= '0;
      burst_cnt   <= '0;
      wdog        <= '0;
      last_q      <= 1'b0;
    end else begin
      if (clear_err) timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && pick_valid) begin
            grant     <= NUM_REQ'(1) << pick_idx;
            active_id <= pick_idx;
            tx_data   <= data_arr[pick_idx];
            burst_cnt <= '0;
            wdog      <= '0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          // A byte presented while the UART is free is always issued; req is only
          // re-examined while waiting so that we/ack never depend on req.
          if (!tx_busy) begin
            last_q    <= req_last[active_id];
            burst_cnt <= burst_cnt + 8'd1;
            wdog      <= '0;
            state     <= WAIT_DONE;
          end else if (wdog_max) begin
            timeout_err <= 1'b1;
            grant       <= '0;
            ptr         <= next_ptr;
            state       <= IDLE;
          end else if (!req[active_id]) begin
            grant <= '0;
            ptr   <= next_ptr;
            state <= IDLE;
          end else begin
            wdog    <= wdog + TIMEOUT_WIDTH'(1);
            tx_data <= data_arr[active_id];
          end
        end
        WAIT_DONE: begin
          if (tx_done) begin
            if (last_q || (burst_cnt == 8'(MAX_BURST)) || !req[active_id] || !enable) begin
              grant <= '0;
              ptr   <= next_ptr;
              state <= IDLE;
            end else begin
              tx_data <= data_arr[active_id];
              state   <= ISSUE;
            end
          end else if (wdog_max) begin
            timeout_err <= 1'b1;
            grant       <= '0;
            ptr         <= next_ptr;
            state       <= IDLE;
          end else begin
            wdog <= wdog + TIMEOUT_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple UART model and byte-stream requesters.
// A short watchdog width keeps the stall test brief.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        resetb;
  logic        enable;
  logic [3:0]  req;
  logic [3:0]  req_last;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [3:0]  grant;
  logic [7:0]  tx_data;
  logic        we;
  logic        tx_busy;
  logic        tx_done;
  logic [1:0]  active_id;
  logic        busy;
  logic        timeout_err;
  logic        clear_err;

  int errors = 0;
  int checks = 0;

  int remain [4];
  int sent [4];
  int base [4];
  int pkt_len [4];
  bit hold [4];
  bit uart_auto;

  int log_id [$];
  int log_data [$];
  int grant_log [$];
  logic [3:0] prev_grant;

  uart_tx_arbiter #(
    .NUM_REQ       (4),
    .LOG2_NUM_REQ  (2),
    .MAX_BURST     (16),
    .TIMEOUT_WIDTH (6)
  ) dut (
    .ifclk       (clk),
    .resetb      (resetb),
    .enable      (enable),
    .req         (req),
    .req_last    (req_last),
    .req_data    (req_data),
    .ack         (ack),
    .grant       (grant),
    .tx_data     (tx_data),
    .we          (we),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .active_id   (active_id),
    .busy        (busy),
    .timeout_err (timeout_err),
    .clear_err   (clear_err)
  );

  always #5 clk = ~clk;

  function automatic int onehot_idx(input logic [3:0] v);
    int r;
    r = -1;
    for (int i = 0; i < 4; i++) if (v[i] === 1'b1) r = i;
    return r;
  endfunction

  function automatic bit streams_empty();
    bit e;
    e = 1'b1;
    for (int i = 0; i < 4; i++) if (remain[i] != 0) e = 1'b0;
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  // Queue a byte stream for one requester; plen=0 means no last marker.
  task automatic applyStimulus(input int id, input int b, input int count, input int plen);
    base[id]    = b;
    sent[id]    = 0;
    pkt_len[id] = plen;
    hold[id]    = 1'b0;
    remain[id]  = count;
  endtask

  task automatic startTest();
    for (int i = 0; i < 4; i++) begin
      remain[i] = 0; sent[i] = 0; base[i] = 0; pkt_len[i] = 0; hold[i] = 1'b0;
    end
    enable = 1'b1; clear_err = 1'b0; tx_busy = 1'b0; tx_done = 1'b0; uart_auto = 1'b1;
    resetb = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetb = 1'b1;
    log_id.delete(); log_data.delete(); grant_log.delete();
  endtask

  task automatic waitIdle(input string tag, input int limit);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (streams_empty() && !busy) begin ok = 1'b1; break; end
    end
    checkOutput(tag, 32'(ok), 32'd1);
  endtask

  // Requesters: observe ack/we/grant mid-cycle, present the next byte after the edge.
  initial begin
    forever begin
      @(negedge clk);
      if (we === 1'b1) begin
        log_id.push_back(onehot_idx(ack));
        log_data.push_back(int'(tx_data));
      end
      for (int i = 0; i < 4; i++) if (ack[i] === 1'b1) begin sent[i]++; remain[i]--; end
      if (grant !== 4'b0 && !$isunknown(grant) && prev_grant === 4'b0)
        grant_log.push_back(onehot_idx(grant));
      prev_grant = grant;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        req[i]             = (remain[i] > 0) && !hold[i];
        req_data[8*i +: 8] = 8'(base[i] + sent[i]);
        req_last[i]        = (pkt_len[i] != 0) && ((sent[i] % pkt_len[i]) == pkt_len[i] - 1);
      end
    end
  end

  // UART model: busy after accepting a byte, tx_done about ten cycles after we.
  initial begin
    forever begin
      @(negedge clk);
      if (we === 1'b1 && uart_auto) begin
        @(posedge clk); #1 tx_busy = 1'b1;
        repeat (9) @(posedge clk);
        #1 tx_busy = 1'b0; tx_done = 1'b1;
        @(posedge clk); #1 tx_done = 1'b0;
      end
    end
  end

  initial begin
    int cnt;
    bit ok;
    req = '0; req_last = '0; req_data = '0;

    // Reset values
    startTest();
    resetb = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_grant", 32'(grant), 32'd0);
    checkOutput("rst_ack", 32'(ack), 32'd0);
    checkOutput("rst_we", 32'(we), 32'd0);
    checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
    checkOutput("rst_active_id", 32'(active_id), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
    resetb = 1'b1;

    // Single 3-byte packet from requester 0
    startTest();
    applyStimulus(0, 'h41, 3, 3);
    waitIdle("t1_done", 500);
    checkOutput("t1_we_count", 32'(log_data.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("t1_data%0d", i), 32'(log_data[i]), 32'h41 + 32'(i));
      checkOutput($sformatf("t1_id%0d", i), 32'(log_id[i]), 32'd0);
    end
    checkOutput("t1_grant_off", 32'(grant), 32'd0);
    checkOutput("t1_active_id", 32'(active_id), 32'd0);
    // Pointer moved to 1: requester 1 beats requester 0
    applyStimulus(0, 'h50, 1, 1);
    applyStimulus(1, 'h60, 1, 1);
    waitIdle("t1b_done", 200);
    checkOutput("t1b_first_owner", 32'(grant_log[1]), 32'd1);
    checkOutput("t1b_first_data", 32'(log_data[3]), 32'h60);
    checkOutput("t1b_second_data", 32'(log_data[4]), 32'h50);

    // Requesters 0 and 2 alternate 2-byte packets
    startTest();
    applyStimulus(0, 'h10, 4, 2);
    applyStimulus(2, 'h20, 4, 2);
    waitIdle("t2_done", 800);
    checkOutput("t2_grants", 32'(grant_log.size()), 32'd4);
    checkOutput("t2_g0", 32'(grant_log[0]), 32'd0);
    checkOutput("t2_g1", 32'(grant_log[1]), 32'd2);
    checkOutput("t2_g2", 32'(grant_log[2]), 32'd0);
    checkOutput("t2_g3", 32'(grant_log[3]), 32'd2);
    checkOutput("t2_d2", 32'(log_data[2]), 32'h20);
    checkOutput("t2_d5", 32'(log_data[5]), 32'h13);

    // Burst limit: requester 1 streams 40 bytes while 3 waits
    startTest();
    applyStimulus(1, 'h80, 40, 0);
    applyStimulus(3, 'h30, 2, 0);
    waitIdle("t3_done", 2000);
    cnt = 0;
    while (cnt < log_id.size() && log_id[cnt] == 1) cnt++;
    checkOutput("t3_first_burst", 32'(cnt), 32'd16);
    checkOutput("t3_switch_id", 32'(log_id[16]), 32'd3);
    checkOutput("t3_switch_data", 32'(log_data[16]), 32'h30);
    checkOutput("t3_total", 32'(log_data.size()), 32'd42);
    checkOutput("t3_grants", 32'(grant_log.size()), 32'd4);
    checkOutput("t3_g1", 32'(grant_log[1]), 32'd3);
    checkOutput("t3_g3", 32'(grant_log[3]), 32'd1);

    // tx_busy held while in ISSUE
    startTest();
    tx_busy = 1'b1;
    applyStimulus(0, 'h5A, 1, 1);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin @(negedge clk); if (grant != 0) begin ok = 1'b1; break; end end
    checkOutput("t4_granted", 32'(ok), 32'd1);
    cnt = 0;
    for (int n = 0; n < 6; n++) begin @(negedge clk); if (we) cnt++; end
    checkOutput("t4_we_held", 32'(cnt), 32'd0);
    checkOutput("t4_busy", 32'(busy), 32'd1);
    @(posedge clk); #1 tx_busy = 1'b0;
    @(negedge clk);
    checkOutput("t4_we_release", 32'(we), 32'd1);
    waitIdle("t4_done", 100);
    checkOutput("t4_data", 32'(log_data[0]), 32'h5A);

    // req dropped while stuck in ISSUE ends the grant without a byte
    startTest();
    tx_busy = 1'b1;
    applyStimulus(2, 'h77, 1, 1);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin @(negedge clk); if (grant != 0) begin ok = 1'b1; break; end end
    checkOutput("t4b_granted", 32'(ok), 32'd1);
    hold[2] = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("t4b_grant", 32'(grant), 32'd0);
    checkOutput("t4b_busy", 32'(busy), 32'd0);
    checkOutput("t4b_no_we", 32'(log_data.size()), 32'd0);

    // Watchdog: tx_done never comes
    startTest();
    uart_auto = 1'b0;
    applyStimulus(1, 'h33, 1, 1);
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin @(negedge clk); if (timeout_err) begin ok = 1'b1; break; end end
    checkOutput("t5_timeout", 32'(ok), 32'd1);
    checkOutput("t5_grant", 32'(grant), 32'd0);
    checkOutput("t5_busy", 32'(busy), 32'd0);
    checkOutput("t5_issued", 32'(log_data.size()), 32'd1);
    repeat (2) @(negedge clk);
    checkOutput("t5_sticky", 32'(timeout_err), 32'd1);
    @(posedge clk); #1 clear_err = 1'b1;
    @(posedge clk); #1 clear_err = 1'b0;
    @(negedge clk);
    checkOutput("t5_cleared", 32'(timeout_err), 32'd0);
    uart_auto = 1'b1;
    applyStimulus(3, 'h44, 1, 1);
    waitIdle("t5_recover", 200);
    checkOutput("t5_new_id", 32'(log_id[1]), 32'd3);
    checkOutput("t5_new_data", 32'(log_data[1]), 32'h44);

    // Reset during WAIT_DONE, late tx_done ignored
    startTest();
    uart_auto = 1'b0;
    applyStimulus(2, 'h99, 1, 1);
    ok = 1'b0;
    for (int n = 0; n < 30; n++) begin @(negedge clk); if (log_data.size() > 0) begin ok = 1'b1; break; end end
    checkOutput("t6_issued", 32'(ok), 32'd1);
    @(posedge clk); #1 resetb = 1'b0;
    @(posedge clk); #1;
    checkOutput("t6_grant", 32'(grant), 32'd0);
    checkOutput("t6_busy", 32'(busy), 32'd0);
    checkOutput("t6_tx_data", 32'(tx_data), 32'd0);
    checkOutput("t6_active_id", 32'(active_id), 32'd0);
    resetb = 1'b1; tx_done = 1'b1;
    @(posedge clk); #1 tx_done = 1'b0;
    @(negedge clk);
    checkOutput("t6_late_done_busy", 32'(busy), 32'd0);
    checkOutput("t6_late_done_we", 32'(we), 32'd0);

    // enable falls mid-packet
    startTest();
    applyStimulus(2, 'h60, 4, 0);
    ok = 1'b0;
    for (int n = 0; n < 30; n++) begin @(negedge clk); if (log_data.size() > 0) begin ok = 1'b1; break; end end
    checkOutput("t7_first_byte", 32'(ok), 32'd1);
    enable = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin @(negedge clk); if (!busy) begin ok = 1'b1; break; end end
    checkOutput("t7_idle", 32'(ok), 32'd1);
    repeat (20) @(negedge clk);
    checkOutput("t7_bytes", 32'(log_data.size()), 32'd1);
    checkOutput("t7_grant", 32'(grant), 32'd0);
    checkOutput("t7_remaining", 32'(remain[2]), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
